// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic library types: FSM state encoding and default operand width
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full subtractor, d = a - b - bin
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one full-subtractor cell and a registered borrow
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] r_sr;
  logic             br;
  logic [CW-1:0]    count;
  logic             fs_d;
  logic             fs_nb;
  logic [WIDTH-1:0] res_next;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (fs_d),
    .bout (fs_nb)
  );

  // r_sr only needs the WIDTH-1 bits already produced; the final bit comes straight from the cell
  assign res_next = {fs_d, r_sr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      br    <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          r_sr  <= res_next[WIDTH-1:1];
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          br    <= fs_nb;
          count <= count + CW'(1);
          if (count == LAST) begin
            diff  <= res_next;
            bout  <= fs_nb;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation; DONE lasts a single cycle
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            r_sr  <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int tests = 0;
  int fails = 0;
  logic [W:0] sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
  endfunction

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; bin = c; start = 1'b1;
    sb.push_back(model(x, y, c));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // cycles counts negedges after the accepting edge; done shows at cycle W+1 (after edge E0+W)
  task automatic wait_done(output int cycles, output int busy_cnt, output logic stable);
    logic [W-1:0] d0;
    d0 = diff;
    cycles = 0; busy_cnt = 0; stable = 1'b1;
    do begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
      if (!done && diff !== d0) stable = 1'b0;
    end while (!done && cycles < W + 10);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (diff !== '0) begin fails++; $display("FAIL reset_diff got=%h exp=00", diff); end
    tests++; if (bout !== 1'b0) begin fails++; $display("FAIL reset_bout got=%b exp=0", bout); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc, bc;
    logic st;
    logic [W:0] exp;
    launch(8'h35, 8'h12, 1'b0);
    wait_done(cyc, bc, st);
    tests++; if (cyc !== W + 1) begin fails++; $display("FAIL basic_latency got=%0d exp=%0d", cyc, W + 1); end
    tests++; if (bc !== W) begin fails++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, W); end
    exp = sb.pop_front();
    tests++; if ({bout, diff} !== exp) begin fails++; $display("FAIL basic_result got=%h exp=%h", {bout, diff}, exp); end
    tests++; if ({bout, diff} !== 9'h023) begin fails++; $display("FAIL basic_const got=%h exp=023", {bout, diff}); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_borrow();
    logic [W-1:0] ta[2] = '{8'h00, 8'h10};
    logic [W-1:0] tb[2] = '{8'h01, 8'h10};
    logic         tc[2] = '{1'b0, 1'b1};
    int cyc, bc;
    logic st;
    logic [W:0] exp;
    for (int i = 0; i < 2; i++) begin
      launch(ta[i], tb[i], tc[i]);
      wait_done(cyc, bc, st);
      exp = sb.pop_front();
      tests++; if ({bout, diff} !== exp) begin fails++; $display("FAIL borrow_result%0d got=%h exp=%h", i, {bout, diff}, exp); end
      tests++; if ({bout, diff} !== 9'h1FF) begin fails++; $display("FAIL borrow_const%0d got=%h exp=1ff", i, {bout, diff}); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    logic st;
    logic [W:0] exp;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; bin = 1'b1; start = 1'b1;
    sb.push_back(model(8'h5A, 8'h3C, 1'b1));
    @(posedge clk);
    #1 a = 8'hAA; b = 8'h55; bin = 1'b0;
    wait_done(cyc, bc, st);
    tests++; if (bc !== W) begin fails++; $display("FAIL held_busy_cycles got=%0d exp=%0d", bc, W); end
    exp = sb.pop_front();
    tests++; if ({bout, diff} !== exp) begin fails++; $display("FAIL held_result got=%h exp=%h", {bout, diff}, exp); end
    // start still high in the DONE cycle: AA/55 accepted on the next edge
    sb.push_back(model(8'hAA, 8'h55, 1'b0));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    tests++; if ({busy, done} !== 2'b10) begin fails++; $display("FAIL b2b_handshake got=%b exp=10", {busy, done}); end
    wait_done(cyc, bc, st);
    tests++; if (cyc !== W) begin fails++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, W); end
    exp = sb.pop_front();
    tests++; if ({bout, diff} !== exp) begin fails++; $display("FAIL b2b_result got=%h exp=%h", {bout, diff}, exp); end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bc;
    logic st;
    logic seen;
    logic [W:0] exp;
    launch(8'h35, 8'h12, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if ({busy, done, bout, diff} !== '0) begin fails++; $display("FAIL midrst_clear got=%b%b%b_%h exp=000_00", busy, done, bout, diff); end
    sb.delete();
    seen = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midrst_no_done got=%b exp=0", seen); end
    launch(8'h80, 8'h01, 1'b0);
    wait_done(cyc, bc, st);
    exp = sb.pop_front();
    tests++; if ({bout, diff} !== 9'h07F) begin fails++; $display("FAIL midrst_next got=%h exp=07f", {bout, diff}); end
    tests++; if ({bout, diff} !== exp) begin fails++; $display("FAIL midrst_next_sb got=%h exp=%h", {bout, diff}, exp); end
  endtask

  task automatic test_random();
    logic [W-1:0] ca[6] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    logic [W-1:0] cb[6] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    logic         cc[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] x, y;
    logic c;
    int cyc, bc;
    logic st;
    logic [W:0] exp;
    for (int i = 0; i < 500; i++) begin
      if (i < 6) begin
        x = ca[i]; y = cb[i]; c = cc[i];
      end else begin
        x = W'($urandom); y = W'($urandom); c = 1'($urandom);
      end
      launch(x, y, c);
      wait_done(cyc, bc, st);
      tests++; if (cyc !== W + 1) begin fails++; $display("FAIL rand_latency i=%0d got=%0d exp=%0d", i, cyc, W + 1); end
      tests++; if (st !== 1'b1) begin fails++; $display("FAIL rand_diff_stable i=%0d got=%b exp=1", i, st); end
      if (sb.size() == 0) begin
        tests++; fails++; $display("FAIL rand_sb_empty i=%0d got=0 exp=1", i);
      end else begin
        exp = sb.pop_front();
        tests++; if ({bout, diff} !== exp) begin fails++; $display("FAIL rand_result i=%0d a=%h b=%h bin=%b got=%h exp=%h", i, x, y, c, {bout, diff}, exp); end
      end
      @(negedge clk);
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL rand_done_pulse i=%0d got=%b exp=0", i, done); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock, through a single full-subtractor cell and a registered borrow.
- It is the inverse-direction companion of the team's combinational full adder. It serves as the area-minimal datapath option in the arithmetic library.
- A start/busy/done handshake frames each operation. Results are held stable until the next operation completes.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend; captured on the accepting edge
b  input  WIDTH  subtrahend; captured on the accepting edge
bin  input  1  borrow-in; captured on the accepting edge
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse; diff/bout valid from this cycle onward
diff  output  WIDTH  result a - b - bin mod 2^WIDTH
bout  output  1  borrow-out (1 when a < b + bin, unsigned)

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, diff=0, bout=0, internal shift registers/borrow/counter=0. Reset overrides all other inputs on the same edge.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE: if start=1 at edge E0:
  - latch a, b into shift registers
  - borrow_reg <= bin, count <= 0
  - go to RUN
  Otherwise stay in IDLE.
- RUN, each edge:
  - d = a0 ^ b0 ^ br
  - nb = (~a0 & b0) | (~(a0 ^ b0) & br)
  - shift d into the MSB of the result shift register
  - shift a/b shift registers right by 1
  - borrow_reg <= nb
  - count++
- RUN exit: on the edge where count == WIDTH-1 (edge E0+WIDTH):
  - diff <= completed result (including the final bit)
  - bout <= nb
  - done <= 1
  - go to DONE
- Latency: done is high in the cycle following edge E0+WIDTH, i.e. exactly WIDTH clocks after the start edge.
- busy = 1 exactly in RUN (WIDTH cycles); it is registered alongside the state.
- DONE (one cycle):
  - done=1
  - if start=1: accept new operands as in IDLE and go to RUN (back-to-back; busy rises, done falls next cycle)
  - else go to IDLE; done=0 next cycle
- start during RUN is ignored. Operands cannot change mid-operation.
- diff/bout change only on the completion edge (or on reset). They are never partially updated.
- Reset mid-RUN: operation aborted, no done pulse, outputs cleared to 0.
- Boundaries:
  - a=b, bin=0 -> diff=0, bout=0
  - a=0, b=0, bin=1 -> diff=all ones, bout=1
  - a=all ones, b=0, bin=0 -> diff=all ones, bout=0
- Counter width is $clog2(WIDTH). It is compared against WIDTH-1, so there is no wrap.

Decomposition:
- Shared package arith_pkg: state encoding constants (ST_IDLE=0, ST_RUN=1, ST_DONE=2) and the default WIDTH.
- Sub-module full_subtractor: combinational, with ports a, b, bin, d, bout. It implements the d/nb equations above.
- serial_subtractor instantiates full_subtractor once. It holds the FSM, counter, and shift registers.

Test Plan:
- WIDTH=8: a=0x35, b=0x12, bin=0, start pulse -> busy high for 8 cycles, done exactly 8 clocks after the start edge, diff=0x23, bout=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
- start held high for the whole operation with a/b changed to 0xAA/0x55 during RUN -> ignored; result equals the first operands' result. A second operation starts from the DONE cycle (back-to-back) and yields the new result WIDTH clocks later.
- rst asserted at cycle 4 of RUN -> next cycle busy=0, done=0, diff=0x00, bout=0, and no done pulse ever. A following op a=0x80, b=0x01 -> diff=0x7F, bout=0.
- 500 random (a, b, bin) operations, including all-zero/all-one corners -> {bout, diff} matches (a - b - bin) mod 2^(WIDTH+1) as an unsigned compare. done is a single-cycle pulse, and diff is stable between done pulses.
